// File: rtl/password_pkg.sv
// password_pkg: shared states and parameter defaults for the password digit interface.
package password_pkg;

    typedef enum logic [1:0] {IDLE, LATCH, SEND, HELD} state_t;

    localparam int DIGIT_W_DEF         = 4;
    localparam int NUM_DIGITS_DEF      = 4;
    localparam int DEBOUNCE_CYCLES_DEF = 500000;
    localparam int DEBOUNCE_CYCLES_SIM = 4;

endpackage

// File: rtl/debounce_sync.sv
// debounce_sync: 2-flop synchronizer plus stable-count debouncer with a one-cycle accept pulse.
module debounce_sync #(
    parameter int   CYCLES     = 4,
    parameter logic SYNC_INIT  = 1'b1,
    parameter logic LEVEL_INIT = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic accept
);

    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic          s0, s1;
    logic [CW-1:0] cnt;
    logic          done;

    assign done = (cnt == CW'(CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0     <= SYNC_INIT;
            s1     <= SYNC_INIT;
            cnt    <= '0;
            level  <= LEVEL_INIT;
            accept <= 1'b0;
        end else begin
            s0     <= din;
            s1     <= s0;
            accept <= 1'b0;
            if (s1 == level) begin
                cnt <= '0;
            end else if (done) begin
                cnt    <= '0;
                level  <= s1;
                accept <= 1'b1;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/password_key_tx.sv
// password_key_tx: debounced push-button plus synchronized switches to an fsm_in/next digit stream.
module password_key_tx
    import password_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int DIGIT_W         = DIGIT_W_DEF,
    parameter int NUM_DIGITS      = NUM_DIGITS_DEF
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              btn_n,
    input  logic [DIGIT_W-1:0]                sw,
    output logic [DIGIT_W-1:0]                fsm_in,
    output logic                              next,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_count,
    output logic                              seq_done
);

    localparam int CNT_W = $clog2(NUM_DIGITS + 1);

    state_t             state_q, state_d;
    logic               btn_level, btn_accept;
    logic [DIGIT_W-1:0] sw_s0, sw_s1;

    // Accepted level starts as pressed so a button held through reset must be released first.
    debounce_sync #(
        .CYCLES    (DEBOUNCE_CYCLES),
        .SYNC_INIT (1'b1),
        .LEVEL_INIT(1'b0)
    ) u_btn (
        .clk   (clk),
        .rst   (rst),
        .din   (btn_n),
        .level (btn_level),
        .accept(btn_accept)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_s0 <= '0;
            sw_s1 <= '0;
        end else begin
            sw_s0 <= sw;
            sw_s1 <= sw_s0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (btn_accept && !btn_level) ? LATCH : IDLE;
            LATCH:   state_d = SEND;
            SEND:    state_d = HELD;
            HELD:    state_d = (btn_accept && btn_level) ? IDLE : HELD;
            default: state_d = IDLE;
        endcase
    end

    // Digit is captured on entry to LATCH so it is stable for a full cycle before next.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_in      <= '0;
            digit_count <= '0;
            seq_done    <= 1'b0;
        end else begin
            if (state_q == IDLE && state_d == LATCH)
                fsm_in <= sw_s1;
            if (state_q == SEND)
                digit_count <= (digit_count == CNT_W'(NUM_DIGITS - 1)) ? '0 : digit_count + CNT_W'(1);
            seq_done <= (state_q == SEND) && (digit_count == CNT_W'(NUM_DIGITS - 1));
        end
    end

    assign next = (state_q == SEND);

endmodule

// File: tb/tb_password_key_tx.sv
// tb_password_key_tx: directed stimulus with a timing-rule reference model and per-cycle compare.
module tb_password_key_tx;
    import password_pkg::*;

    localparam int DC = DEBOUNCE_CYCLES_SIM;
    localparam int DW = 4;
    localparam int ND = 4;
    localparam int CW = $clog2(ND + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          btn_n = 1'b1;
    logic [DW-1:0] sw = '0;
    logic [DW-1:0] fsm_in;
    logic          next;
    logic [CW-1:0] digit_count;
    logic          seq_done;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always #10 clk = ~clk;

    password_key_tx #(
        .DEBOUNCE_CYCLES(DC),
        .DIGIT_W        (DW),
        .NUM_DIGITS     (ND)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_n      (btn_n),
        .sw         (sw),
        .fsm_in     (fsm_in),
        .next       (next),
        .digit_count(digit_count),
        .seq_done   (seq_done)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: inputs seen two edges late, a press is accepted after DC consecutive
    // differing samples; then digit captured +1 edge, strobe +2, count/wrap +3.
    logic          bh0 = 1'b1, bh1 = 1'b1, bs, acc = 1'b0;
    logic [DW-1:0] sh0 = '0, sh1 = '0, ss;
    logic [DW-1:0] e_fsm = '0;
    logic          e_next = 1'b0, e_done = 1'b0;
    int            e_cnt = 0, run = 0, pend = 0;

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            bh0 = 1'b1; bh1 = 1'b1; sh0 = '0; sh1 = '0; acc = 1'b0;
            run = 0; pend = 0; e_fsm = '0; e_next = 1'b0; e_done = 1'b0; e_cnt = 0;
        end else begin
            bs = bh1; ss = sh1;
            bh1 = bh0; bh0 = btn_n;
            sh1 = sh0; sh0 = sw;
            e_next = 1'b0;
            e_done = 1'b0;
            if (pend == 3) e_fsm = ss;
            else if (pend == 2) e_next = 1'b1;
            else if (pend == 1) begin
                if (e_cnt == ND - 1) begin
                    e_cnt = 0;
                    e_done = 1'b1;
                end else e_cnt++;
            end
            if (pend > 0) pend--;
            if (bs != acc) begin
                run++;
                if (run == DC) begin
                    acc = bs;
                    run = 0;
                    if (!acc) pend = 3;
                end
            end else run = 0;
        end
    end

    int            n_next = 0, n_done = 0, last_next_cyc = 0, last_done_cyc = 0, press_cyc = 0;
    logic [DW-1:0] prev_fsm = '0, pre_fsm = '0;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            total++;
            if (fsm_in !== e_fsm || next !== e_next || int'(digit_count) != e_cnt || seq_done !== e_done) begin
                bad++;
                $display("FAIL model cyc=%0d fsm_in=%0h/%0h next=%b/%b cnt=%0d/%0d done=%b/%b (got/exp)",
                         cyc, fsm_in, e_fsm, next, e_next, digit_count, e_cnt, seq_done, e_done);
            end
        end
        if (next) begin
            n_next++;
            last_next_cyc = cyc;
            pre_fsm = prev_fsm;
        end
        prev_fsm = fsm_in;
        if (seq_done) begin
            n_done++;
            last_done_cyc = cyc;
        end
    end

    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic press(logic [DW-1:0] v, int hold, int gap);
        tick(1);
        sw = v;
        btn_n = 1'b0;
        press_cyc = cyc;
        tick(hold);
        btn_n = 1'b1;
        tick(gap);
    endtask

    task automatic do_reset();
        tick(1);
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(10);
    endtask

    initial begin
        int n0, d0, lat;
        logic seen;
        tick(3);
        chk("rst_fsm_in", int'(fsm_in), 0);
        chk("rst_next", int'(next), 0);
        chk("rst_count", int'(digit_count), 0);
        chk("rst_done", int'(seq_done), 0);
        rst = 1'b1;
        tick(10);

        n0 = n_next;
        press(4'h1, 10, 12);
        chk("t1_pulses", n_next - n0, 1);
        chk("t1_fsm_before_next", int'(pre_fsm), 1);
        chk("t1_fsm_in", int'(fsm_in), 1);
        chk("t1_count", int'(digit_count), 1);
        chk("t1_latency", last_next_cyc - press_cyc, DC + 4);

        do_reset();
        n0 = n_next;
        d0 = n_done;
        for (int i = 1; i <= 4; i++) begin
            press(DW'(i), 10, 12);
            chk("t2_fsm_in", int'(fsm_in), i);
        end
        chk("t2_pulses", n_next - n0, 4);
        chk("t2_count_wrap", int'(digit_count), 0);
        chk("t2_done_pulses", n_done - d0, 1);
        chk("t2_done_after_next", last_done_cyc - last_next_cyc, 1);

        n0 = n_next;
        tick(1);
        btn_n = 1'b0;
        tick(3);
        btn_n = 1'b1;
        tick(12);
        chk("t3_bounce_pulses", n_next - n0, 0);
        chk("t3_bounce_count", int'(digit_count), 0);
        tick(1);
        sw = 4'h5;
        btn_n = 1'b0;
        tick(12);
        btn_n = 1'b1;
        tick(3);
        btn_n = 1'b0;
        sw = 4'h9;
        tick(15);
        chk("t3_held_pulses", n_next - n0, 1);
        chk("t3_fsm_hold", int'(fsm_in), 5);
        chk("t3_count", int'(digit_count), 1);
        btn_n = 1'b1;
        tick(12);
        press(4'h9, 10, 12);
        chk("t3_fsm_new", int'(fsm_in), 9);
        chk("t3_count2", int'(digit_count), 2);

        tick(1);
        sw = 4'h7;
        btn_n = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = next;
        end
        chk("t4_send_seen", int'(seen), 1);
        #2 rst = 1'b0;
        #1;
        chk("t4_send_rst_fsm", int'(fsm_in), 0);
        chk("t4_send_rst_next", int'(next), 0);
        chk("t4_send_rst_count", int'(digit_count), 0);
        chk("t4_send_rst_done", int'(seq_done), 0);
        tick(2);
        rst = 1'b1;
        n0 = n_next;
        tick(20);
        chk("t4_held_no_strobe", n_next - n0, 0);
        btn_n = 1'b1;
        tick(12);
        press(4'h3, 10, 12);
        chk("t4_repress_pulses", n_next - n0, 1);
        chk("t4_repress_fsm", int'(fsm_in), 3);
        chk("t4_repress_count", int'(digit_count), 1);

        tick(1);
        sw = 4'h6;
        btn_n = 1'b0;
        tick(15);
        chk("t4_held_fsm", int'(fsm_in), 6);
        rst = 1'b0;
        #1;
        chk("t4_held_rst_fsm", int'(fsm_in), 0);
        chk("t4_held_rst_count", int'(digit_count), 0);
        tick(2);
        rst = 1'b1;
        n0 = n_next;
        tick(20);
        chk("t4_held2_no_strobe", n_next - n0, 0);
        btn_n = 1'b1;
        tick(12);
        press(4'h8, 10, 12);
        chk("t4_held2_pulses", n_next - n0, 1);
        chk("t4_held2_fsm", int'(fsm_in), 8);

        n0 = n_next;
        press(4'h2, 100, 12);
        lat = last_next_cyc - press_cyc;
        chk("t5_pulses", n_next - n0, 1);
        chk("t5_latency_window", int'(lat >= DC + 3 && lat <= DC + 5), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not reach the end");
        $fatal(1);
    end

endmodule
